// File: rtl/cp0_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_ctrl_if
//  Purpose  : Bundle of M-stage request signals and CP0 responses exchanged
//             between the pipeline and the coprocessor-0 controller.
//  Revision : 1.0  initial release
// ============================================================================
interface cp0_ctrl_if;
    logic        valid_M;
    logic [31:0] pc_M;
    logic        bd_M;
    logic [4:0]  excode_M;
    logic        eret_M;
    logic        we_M;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [5:0]  hwint;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] target_pc;
    logic [31:0] epc_out;
    logic        exl;

    // Pipeline side: presents the M-stage instruction, consumes redirects
    modport master (
        output valid_M, pc_M, bd_M, excode_M, eret_M, we_M, addr, wdata, hwint,
        input  rdata, req, target_pc, epc_out, exl
    );

    // Controller side
    modport slave (
        input  valid_M, pc_M, bd_M, excode_M, eret_M, we_M, addr, wdata, hwint,
        output rdata, req, target_pc, epc_out, exl
    );
endinterface
`default_nettype wire

// File: rtl/cp0_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_ctrl
//  Purpose  : Coprocessor-0 exception/interrupt controller. Decides handler
//             entry from the M-stage instruction and hwint, keeps SR, Cause,
//             EPC and PRId, serves mfc0/mtc0 and sequences eret.
//  Options  : CP0_INT_SYNC_EN - register hwint once before it becomes IP.
//  Revision : 1.0  initial release
// ============================================================================
module cp0_ctrl #(
    parameter logic [31:0] PRID         = 32'h2021_0607,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  wire logic   clk,
    input  wire logic   reset,
    cp0_ctrl_if.slave   bus
);

    localparam logic [4:0] C_EXC_NONE = 5'd31;
    localparam logic [4:0] C_REG_SR   = 5'd12;
    localparam logic [4:0] C_REG_CAUSE= 5'd13;
    localparam logic [4:0] C_REG_EPC  = 5'd14;
    localparam logic [4:0] C_REG_PRID = 5'd15;

    // EXL doubles as the controller state
    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t      r_state;
    logic [5:0]  r_im;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic [5:0]  w_ip;
    logic        w_in_run;
    logic        w_int_p;
    logic        w_exc_p;
    logic        w_req;

`ifdef CP0_INT_SYNC_EN
    logic [5:0]  r_hw_sync;

    // One-flop stage between the interrupt pins and IP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_hw_sync <= 6'd0;
        else       r_hw_sync <= bus.hwint;
    end

    assign w_ip = r_hw_sync;
`else
    assign w_ip = bus.hwint;
`endif

    // Entry decision: only a real instruction outside the handler can trap;
    // an unmasked interrupt outranks any synchronous exception.
    assign w_in_run = (r_state == RUN);
    assign w_int_p  = (|(w_ip & r_im)) & r_ie & w_in_run & bus.valid_M;
    assign w_exc_p  = (bus.excode_M != C_EXC_NONE) & w_in_run & bus.valid_M;
    assign w_req    = w_int_p | w_exc_p;

    // State and CP0 register updates: trap entry beats mtc0, eret leaves handler
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_im       <= 6'd0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_cause_ip <= 6'd0;
            r_exc_code <= 5'd0;
            r_epc      <= 32'd0;
        end else begin
            r_cause_ip <= w_ip;
            if (w_req) begin
                r_state    <= HANDLER;
                r_exc_code <= w_int_p ? 5'd0 : bus.excode_M;
                r_bd       <= bus.bd_M;
                r_epc      <= bus.bd_M ? (bus.pc_M - 32'd4) : bus.pc_M;
            end else begin
                if (bus.we_M && (bus.addr == C_REG_SR)) begin
                    r_im    <= bus.wdata[15:10];
                    r_ie    <= bus.wdata[0];
                    r_state <= bus.wdata[1] ? HANDLER : RUN;
                end
                if (bus.we_M && (bus.addr == C_REG_EPC)) begin
                    r_epc <= bus.wdata;
                end
                if (bus.eret_M && bus.valid_M) begin
                    r_state <= RUN;
                end
            end
        end
    end

    // mfc0 read mux; unimplemented numbers and fields read as zero
    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            C_REG_SR:    bus.rdata = {16'd0, r_im, 8'd0, (r_state == HANDLER), r_ie};
            C_REG_CAUSE: bus.rdata = {r_bd, 15'd0, r_cause_ip, 3'd0, r_exc_code, 2'd0};
            C_REG_EPC:   bus.rdata = r_epc;
            C_REG_PRID:  bus.rdata = PRID;
            default:     bus.rdata = 32'd0;
        endcase
    end

    assign bus.req       = w_req;
    assign bus.epc_out   = r_epc;
    assign bus.exl       = (r_state == HANDLER);
    assign bus.target_pc = w_req ? HANDLER_ADDR : r_epc;

endmodule
`default_nettype wire

// File: tb/tb_cp0_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cp0_ctrl
//  Purpose  : Self-checking bench for cp0_ctrl: directed vector table, async
//             reset mid-handler, then random traffic against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cp0_ctrl;

    localparam logic [31:0] C_PRID = 32'h2021_0607;
    localparam logic [31:0] C_HAND = 32'h0000_4180;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    cp0_ctrl_if bus();

    cp0_ctrl #(.PRID(C_PRID), .HANDLER_ADDR(C_HAND)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  excode;
        logic        eret;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [5:0]  hwint;
        logic        ereq;
        logic [31:0] etgt;
        logic [31:0] erd;
        logic        eexl;
        logic [31:0] eepc;
    } vec_t;

    vec_t tv[$];

    // Reference model state, in architectural terms
    logic [5:0]  m_im;
    logic        m_ie;
    logic        m_exl;
    logic        m_bd;
    logic [5:0]  m_ip;
    logic [4:0]  m_code;
    logic [31:0] m_epc;
    logic [5:0]  m_hwq;

    function automatic vec_t mk(
        input logic v, input logic [31:0] pc, input logic bd, input logic [4:0] ex,
        input logic er, input logic we, input logic [4:0] a, input logic [31:0] wd,
        input logic [5:0] hw, input logic rq, input logic [31:0] tg,
        input logic [31:0] rd, input logic xl, input logic [31:0] ep);
        vec_t t;
        t.valid = v;  t.pc = pc;   t.bd = bd;   t.excode = ex; t.eret = er;
        t.we = we;    t.addr = a;  t.wdata = wd; t.hwint = hw;
        t.ereq = rq;  t.etgt = tg; t.erd = rd;  t.eexl = xl;   t.eepc = ep;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.valid_M  = t.valid;
        bus.pc_M     = t.pc;
        bus.bd_M     = t.bd;
        bus.excode_M = t.excode;
        bus.eret_M   = t.eret;
        bus.we_M     = t.we;
        bus.addr     = t.addr;
        bus.wdata    = t.wdata;
        bus.hwint    = t.hwint;
    endtask

    task automatic model_reset();
        m_im = 6'd0; m_ie = 1'b0; m_exl = 1'b0; m_bd = 1'b0;
        m_ip = 6'd0; m_code = 5'd0; m_epc = 32'd0; m_hwq = 6'd0;
    endtask

    function automatic logic [5:0] m_ip_now();
`ifdef CP0_INT_SYNC_EN
        return m_hwq;
`else
        return bus.hwint;
`endif
    endfunction

    function automatic logic m_take_int();
        return bus.valid_M && !m_exl && m_ie && ((m_ip_now() & m_im) != 6'd0);
    endfunction

    function automatic logic m_take_exc();
        return bus.valid_M && !m_exl && (bus.excode_M != 5'd31);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13:   return (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_code) << 2);
            5'd14:   return m_epc;
            5'd15:   return C_PRID;
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs still on the bus
    task automatic model_step();
        logic ti, te;
        logic [5:0] ipn;
        ti  = m_take_int();
        te  = m_take_exc();
        ipn = m_ip_now();
        if (ti || te) begin
            m_code = ti ? 5'd0 : bus.excode_M;
            m_bd   = bus.bd_M;
            m_epc  = bus.bd_M ? bus.pc_M - 32'd4 : bus.pc_M;
            m_exl  = 1'b1;
        end else begin
            if (bus.we_M && bus.addr == 5'd12) begin
                m_im  = bus.wdata[15:10];
                m_exl = bus.wdata[1];
                m_ie  = bus.wdata[0];
            end
            if (bus.we_M && bus.addr == 5'd14) m_epc = bus.wdata;
            if (bus.eret_M && bus.valid_M) m_exl = 1'b0;
        end
        m_ip  = ipn;
        m_hwq = bus.hwint;
    endtask

    task automatic idle();
        drive(mk(0, 32'd0, 0, 5'd31, 0, 0, 5'd0, 32'd0, 6'd0, 0, 0, 0, 0, 0));
    endtask

    logic [4:0] exc_tab [6];

    initial begin
        errors = 0;
        checks = 0;
        exc_tab[0] = 5'd0;  exc_tab[1] = 5'd4;  exc_tab[2] = 5'd5;
        exc_tab[3] = 5'd10; exc_tab[4] = 5'd12; exc_tab[5] = 5'd31;

        //             v  pc          bd ex    er we addr   wdata         hw     rq tgt         rdata         exl epc
`ifndef CP0_INT_SYNC_EN
        tv.push_back(mk(0, 32'h0,     0, 5'd31, 0, 0, 5'd12, 32'h0,        6'd0, 0, 32'h0,     32'h0,        0, 32'h0));
        tv.push_back(mk(0, 32'h0,     0, 5'd31, 0, 0, 5'd13, 32'h0,        6'd0, 0, 32'h0,     32'h0,        0, 32'h0));
        tv.push_back(mk(0, 32'h0,     0, 5'd31, 0, 0, 5'd14, 32'h0,        6'd0, 0, 32'h0,     32'h0,        0, 32'h0));
        tv.push_back(mk(0, 32'h0,     0, 5'd31, 0, 0, 5'd15, 32'h0,        6'd0, 0, 32'h0,     C_PRID,       0, 32'h0));
        tv.push_back(mk(1, 32'h3000,  0, 5'd31, 0, 1, 5'd12, 32'h401,      6'd0, 0, 32'h0,     32'h0,        0, 32'h0));
        tv.push_back(mk(0, 32'h0,     0, 5'd31, 0, 0, 5'd12, 32'h0,        6'd0, 0, 32'h0,     32'h401,      0, 32'h0));
        tv.push_back(mk(1, 32'h3010,  0, 5'd31, 0, 0, 5'd12, 32'h0,        6'd1, 1, C_HAND,    32'h401,      0, 32'h0));
        tv.push_back(mk(0, 32'h0,     0, 5'd31, 0, 0, 5'd13, 32'h0,        6'd0, 0, 32'h3010,  32'h400,      1, 32'h3010));
        tv.push_back(mk(0, 32'h0,     0, 5'd31, 0, 0, 5'd14, 32'h0,        6'd0, 0, 32'h3010,  32'h3010,     1, 32'h3010));
        tv.push_back(mk(1, 32'h3050,  0, 5'd12, 0, 0, 5'd13, 32'h0,        6'd0, 0, 32'h3010,  32'h0,        1, 32'h3010));
        tv.push_back(mk(1, 32'h3054,  0, 5'd31, 1, 0, 5'd14, 32'h0,        6'd0, 0, 32'h3010,  32'h3010,     1, 32'h3010));
        tv.push_back(mk(0, 32'h0,     0, 5'd31, 0, 0, 5'd12, 32'h0,        6'd0, 0, 32'h3010,  32'h401,      0, 32'h3010));
        tv.push_back(mk(1, 32'h3020,  1, 5'd4,  0, 0, 5'd12, 32'h0,        6'd1, 1, C_HAND,    32'h401,      0, 32'h3010));
        tv.push_back(mk(0, 32'h0,     0, 5'd31, 0, 0, 5'd13, 32'h0,        6'd0, 0, 32'h301c,  32'h8000_0400,1, 32'h301c));
        tv.push_back(mk(1, 32'h3024,  0, 5'd31, 1, 0, 5'd14, 32'h0,        6'd0, 0, 32'h301c,  32'h301c,     1, 32'h301c));
        tv.push_back(mk(1, 32'h3040,  0, 5'd10, 0, 1, 5'd14, 32'h3abc,     6'd0, 1, C_HAND,    32'h301c,     0, 32'h301c));
        tv.push_back(mk(0, 32'h0,     0, 5'd31, 0, 0, 5'd13, 32'h0,        6'd0, 0, 32'h3040,  32'h28,       1, 32'h3040));
        tv.push_back(mk(0, 32'h0,     0, 5'd31, 0, 0, 5'd14, 32'h0,        6'd0, 0, 32'h3040,  32'h3040,     1, 32'h3040));
        tv.push_back(mk(1, 32'h3044,  0, 5'd31, 1, 0, 5'd15, 32'h0,        6'd0, 0, 32'h3040,  C_PRID,       1, 32'h3040));
        tv.push_back(mk(0, 32'h0,     0, 5'd31, 0, 0, 5'd0,  32'h0,        6'd1, 0, 32'h3040,  32'h0,        0, 32'h3040));
        tv.push_back(mk(1, 32'h3060,  0, 5'd31, 0, 0, 5'd12, 32'h0,        6'd1, 1, C_HAND,    32'h401,      0, 32'h3040));
        tv.push_back(mk(0, 32'h0,     0, 5'd31, 0, 0, 5'd14, 32'h0,        6'd0, 0, 32'h3060,  32'h3060,     1, 32'h3060));
        tv.push_back(mk(1, 32'h3064,  0, 5'd31, 0, 1, 5'd13, 32'hffff_ffff,6'd0, 0, 32'h3060,  32'h0,        1, 32'h3060));
        tv.push_back(mk(0, 32'h0,     0, 5'd31, 0, 0, 5'd13, 32'h0,        6'd0, 0, 32'h3060,  32'h0,        1, 32'h3060));
`else
        tv.push_back(mk(1, 32'h3000,  0, 5'd31, 0, 1, 5'd12, 32'h401,      6'd0, 0, 32'h0,     32'h0,        0, 32'h0));
        tv.push_back(mk(1, 32'h3100,  0, 5'd31, 0, 0, 5'd12, 32'h0,        6'd1, 0, 32'h0,     32'h401,      0, 32'h0));
        tv.push_back(mk(0, 32'h0,     0, 5'd31, 0, 0, 5'd12, 32'h0,        6'd1, 0, 32'h0,     32'h401,      0, 32'h0));
        tv.push_back(mk(1, 32'h3108,  0, 5'd31, 0, 0, 5'd12, 32'h0,        6'd1, 1, C_HAND,    32'h401,      0, 32'h0));
        tv.push_back(mk(0, 32'h0,     0, 5'd31, 0, 0, 5'd14, 32'h0,        6'd0, 0, 32'h3108,  32'h3108,     1, 32'h3108));
`endif

        // Power-on reset
        reset = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Directed vector table; the model shadows it so random traffic can follow
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            @(negedge clk);
            chk($sformatf("vec%0d req", i),       32'(bus.req),   32'(tv[i].ereq));
            chk($sformatf("vec%0d target_pc", i), bus.target_pc,  tv[i].etgt);
            chk($sformatf("vec%0d rdata", i),     bus.rdata,      tv[i].erd);
            chk($sformatf("vec%0d exl", i),       32'(bus.exl),   32'(tv[i].eexl));
            chk($sformatf("vec%0d epc_out", i),   bus.epc_out,    tv[i].eepc);
            @(posedge clk);
            model_step();
            #1;
        end

        // Asynchronous reset while inside the handler
        idle();
        @(negedge clk);
        chk("pre-reset exl", 32'(bus.exl), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async reset exl",       32'(bus.exl),  32'd0);
        chk("async reset epc_out",   bus.epc_out,   32'd0);
        chk("async reset req",       32'(bus.req),  32'd0);
        chk("async reset target_pc", bus.target_pc, 32'd0);
        bus.addr = 5'd12;
        #1 chk("async reset SR", bus.rdata, 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;

        // Randomized traffic against the reference model
        for (int n = 0; n < 800; n++) begin
            bus.valid_M  = ($urandom_range(0, 3) != 0);
            bus.pc_M     = {$urandom_range(0, 32'hffff), 2'b00};
            bus.bd_M     = $urandom_range(0, 1);
            bus.excode_M = ($urandom_range(0, 3) == 0) ? exc_tab[$urandom_range(0, 4)] : 5'd31;
            bus.we_M     = ($urandom_range(0, 5) == 0);
            bus.eret_M   = !bus.we_M && ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 4))
                0:       bus.addr = 5'd12;
                1:       bus.addr = 5'd13;
                2:       bus.addr = 5'd14;
                3:       bus.addr = 5'd15;
                default: bus.addr = 5'($urandom_range(0, 31));
            endcase
            bus.wdata    = $urandom;
            bus.hwint    = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            @(negedge clk);
            chk("rand req",       32'(bus.req), 32'(m_take_int() || m_take_exc()));
            chk("rand target_pc", bus.target_pc,
                (m_take_int() || m_take_exc()) ? C_HAND : m_epc);
            chk("rand rdata",     bus.rdata,    m_read(bus.addr));
            chk("rand exl",       32'(bus.exl), 32'(m_exl));
            chk("rand epc_out",   bus.epc_out,  m_epc);
            @(posedge clk);
            model_step();
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
